// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and fetch state encodings for the instruction-fetch stage.
package if_fetch_pkg;
    localparam logic [31:0] ZeroWord  = 32'h0;
    localparam logic [2:0]  InstBytes = 3'd4;
    typedef enum logic {FetchState = 1'b0, FetchValid = 1'b1} fetch_state_e;
endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped instruction cache (valid/tag/inst per entry), built only with ICACHE_EN.
`ifdef ICACHE_EN
module if_icache #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] pc_i,
    input  logic        fill_i,
    input  logic [31:0] fill_inst_i,
    output logic        hit_o,
    output logic [31:0] inst_o
);
    localparam int IW = $clog2(DEPTH);
    logic [DEPTH-1:0]  valid_q;
    logic [31-IW-2:0]  tag_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [IW-1:0]     idx;
    logic [31-IW-2:0]  tag;
    assign idx    = pc_i[IW+1:2];
    assign tag    = pc_i[31:IW+2];
    assign hit_o  = valid_q[idx] && (tag_q[idx] == tag);
    assign inst_o = data_q[idx];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else if (fill_i) valid_q[idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fill_inst_i;
        end
    end
endmodule
`endif

// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch feeding decode via flag/pc/inst, with stall hold and jump redirect.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
`ifdef ICACHE_EN
    , parameter int ICACHE_DEPTH = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        flag_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, inst_q, inst_d;
    logic [2:0]   req_cnt_q, req_cnt_d, rcv_cnt_q, rcv_cnt_d;
    logic         pend_q, pend_d, discard_q, discard_d;
    logic         gnt, rx, done, hit;
    logic [31:0]  hit_inst;
`ifdef ICACHE_EN
    logic lookup, hit_raw, fill;
    // Lookup only in the first FETCH cycle, before any byte has been requested.
    assign lookup = (state_q == FetchState) && (req_cnt_q == 3'd0) && (rcv_cnt_q == 3'd0);
    assign hit    = lookup && hit_raw;
    assign fill   = done && !jump_i;
    if_icache #(.DEPTH(ICACHE_DEPTH)) u_icache (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_q[31:2]),
        .fill_i      (fill),
        .fill_inst_i (inst_d),
        .hit_o       (hit_raw),
        .inst_o      (hit_inst)
    );
`else
    assign hit      = 1'b0;
    assign hit_inst = ZeroWord;
`endif
    // Gated by rst so the request drops the instant reset asserts.
    assign mem_req_o  = rst && (state_q == FetchState) && (req_cnt_q != InstBytes) && !hit;
    assign mem_addr_o = mem_req_o ? pc_q + {29'b0, req_cnt_q} : ZeroWord;
    assign flag_o     = (state_q == FetchValid);
    assign pc_o       = flag_o ? pc_q : ZeroWord;
    assign inst_o     = flag_o ? inst_q : ZeroWord;
    assign gnt        = mem_req_o && mem_grant_i;
    assign rx         = pend_q && !discard_q;
    assign done       = rx && (rcv_cnt_q == InstBytes - 3'd1);
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        req_cnt_d = req_cnt_q + {2'b0, gnt};
        rcv_cnt_d = rcv_cnt_q + {2'b0, rx};
        pend_d    = gnt;
        discard_d = 1'b0;
        if (rx) inst_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
        if (jump_i) begin
            state_d   = FetchState;
            pc_d      = jump_addr_i;
            req_cnt_d = 3'd0;
            rcv_cnt_d = 3'd0;
            discard_d = gnt;
        end else if (state_q == FetchValid) begin
            if (!stall_i) begin
                state_d   = FetchState;
                pc_d      = pc_q + 32'd4;
                req_cnt_d = 3'd0;
                rcv_cnt_d = 3'd0;
            end
        end else if (hit) begin
            state_d = FetchValid;
            inst_d  = hit_inst;
        end else if (done) begin
            state_d = FetchValid;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FetchState;
            pc_q      <= RESET_PC;
            inst_q    <= ZeroWord;
            req_cnt_q <= 3'd0;
            rcv_cnt_q <= 3'd0;
            pend_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            pend_q    <= pend_d;
            discard_q <= discard_d;
        end
    end
endmodule
